adc_align_ctl: RTL and testbench

ADC_ALIGN_CTL -- requirements
Module: adc_align_ctl

---
 rtl/adc_align_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_adc_align_ctl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_align_ctl.sv
// adc_align_ctl: per-lane ISERDES bitslip alignment controller.
// Each lane waits, compares its word to a training pattern, and either
// slips one bit and retries, locks after a run of matches, or gives up.
// In coherent mode lane 0 alone is aligned and its slips and status are
// broadcast to every enabled lane.
module adc_align_ctl #(
  parameter int NLANES  = 9,
  parameter int W       = 6,
  parameter int HOLDOFF = 3,
  parameter int LOCKCNT = 16,
  parameter int CNTW    = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NLANES*W-1:0]    DATA,
  input  logic [NLANES*W-1:0]    PATTERN,
  input  logic [NLANES-1:0]      MASK,
  input  logic                   COHERENT,
  input  logic                   START,
  output logic [NLANES-1:0]      BS,
  output logic [NLANES-1:0]      LOCKED,
  output logic [NLANES-1:0]      FAIL,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [NLANES*4-1:0]    SLIP_CNT,
  output logic [NLANES*CNTW-1:0] ERR_CNT
);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, SLIP, LOCK, FAILED} state_t;

  // Hold counter runs 0..HOLDOFF-1, match counter runs 0..LOCKCNT-1.
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int MCW = (LOCKCNT > 1) ? $clog2(LOCKCNT) : 1;

  state_t            st_q   [NLANES];
  state_t            st_nx  [NLANES];
  logic [HCW-1:0]    hold_q [NLANES];
  logic [HCW-1:0]    hold_nx[NLANES];
  logic [MCW-1:0]    mcnt_q [NLANES];
  logic [MCW-1:0]    mcnt_nx[NLANES];
  logic [3:0]        slip_q [NLANES];
  logic [3:0]        slip_nx[NLANES];
  logic [CNTW-1:0]   err_q  [NLANES];
  logic [CNTW-1:0]   err_nx [NLANES];

  logic [NLANES-1:0] bs_q, bs_nx;
  logic [NLANES-1:0] locked_q, locked_nx;
  logic [NLANES-1:0] fail_q, fail_nx;
  logic [NLANES-1:0] en_q, en_nx;
  logic [NLANES-1:0] match;
  logic              coh_q, coh_nx;
  logic              busy_q, busy_nx;
  logic              fell_q, fell_nx;
  logic              done_q;

  // Error counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Per-lane comparison of the received word against its training word.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      match[i] = (DATA[W*i +: W] == PATTERN[W*i +: W]);
    end
  end

  // Next-state and next-output logic for every lane, then coherent mirroring.
  always_comb begin
    coh_nx = START ? COHERENT : coh_q;
    en_nx  = START ? MASK : en_q;
    bs_nx     = '0;
    fail_nx   = fail_q;
    locked_nx = '0;
    for (int i = 0; i < NLANES; i++) begin
      st_nx[i]     = st_q[i];
      hold_nx[i]   = hold_q[i];
      mcnt_nx[i]   = mcnt_q[i];
      slip_nx[i]   = slip_q[i];
      err_nx[i]    = err_q[i];
      locked_nx[i] = (st_q[i] == LOCK);

      case (st_q[i])
        WAIT: begin
          if (hold_q[i] == HCW'(HOLDOFF - 1)) begin
            st_nx[i]   = CHECK;
            hold_nx[i] = '0;
            mcnt_nx[i] = '0;
          end else begin
            hold_nx[i] = hold_q[i] + HCW'(1);
          end
        end
        CHECK: begin
          if (match[i]) begin
            if (mcnt_q[i] == MCW'(LOCKCNT - 1)) st_nx[i] = LOCK;
            else                                mcnt_nx[i] = mcnt_q[i] + MCW'(1);
          end else if (slip_q[i] < 4'(W - 1)) begin
            st_nx[i] = SLIP;
            bs_nx[i] = 1'b1;
          end else begin
            st_nx[i]   = FAILED;
            fail_nx[i] = 1'b1;
          end
        end
        SLIP: begin
          slip_nx[i] = slip_q[i] + 4'd1;
          hold_nx[i] = '0;
          st_nx[i]   = WAIT;
        end
        IDLE, LOCK, FAILED: ;
        default: st_nx[i] = IDLE;
      endcase

      // Errors are counted against this lane's own pattern whenever the
      // controlling FSM (own lane, or lane 0 in coherent mode) is locked.
      if (en_q[i] && ((coh_q ? st_q[0] : st_q[i]) == LOCK) && !match[i]) begin
        err_nx[i] = sat_inc(err_q[i]);
      end

      if (START) begin
        st_nx[i]     = (MASK[i] && (!COHERENT || i == 0)) ? WAIT : IDLE;
        hold_nx[i]   = '0;
        mcnt_nx[i]   = '0;
        slip_nx[i]   = '0;
        err_nx[i]    = '0;
        bs_nx[i]     = 1'b0;
        fail_nx[i]   = 1'b0;
        locked_nx[i] = 1'b0;
      end
    end

    // In coherent mode the idle follower lanes take lane 0's status and slips.
    for (int i = 1; i < NLANES; i++) begin
      if (coh_nx && en_nx[i]) begin
        bs_nx[i]     = bs_nx[0];
        slip_nx[i]   = slip_nx[0];
        fail_nx[i]   = fail_nx[0];
        locked_nx[i] = locked_nx[0];
      end
    end

    busy_nx = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (st_nx[i] inside {WAIT, CHECK, SLIP}) busy_nx = 1'b1;
    end
    // A START cycle never counts as the end of a run.
    fell_nx = busy_q && !busy_nx && !START;
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NLANES; i++) begin
        st_q[i]   <= IDLE;
        hold_q[i] <= '0;
        mcnt_q[i] <= '0;
        slip_q[i] <= '0;
        err_q[i]  <= '0;
      end
      bs_q     <= '0;
      locked_q <= '0;
      fail_q   <= '0;
      en_q     <= '0;
      coh_q    <= 1'b0;
      busy_q   <= 1'b0;
      fell_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        st_q[i]   <= st_nx[i];
        hold_q[i] <= hold_nx[i];
        mcnt_q[i] <= mcnt_nx[i];
        slip_q[i] <= slip_nx[i];
        err_q[i]  <= err_nx[i];
      end
      bs_q     <= bs_nx;
      locked_q <= locked_nx;
      fail_q   <= fail_nx;
      en_q     <= en_nx;
      coh_q    <= coh_nx;
      busy_q   <= busy_nx;
      fell_q   <= fell_nx;
      done_q   <= fell_q;
    end
  end

  // Pack per-lane counters onto the flat output buses.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      SLIP_CNT[4*i +: 4]       = slip_q[i];
      ERR_CNT[CNTW*i +: CNTW]  = err_q[i];
    end
  end

  assign BS     = bs_q;
  assign LOCKED = locked_q;
  assign FAIL   = fail_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_adc_align_ctl.sv
// tb_adc_align_ctl: directed bench for adc_align_ctl with a lane model that
// rotates each lane's word back by one bit per BS pulse, and a scoreboard of
// expected end-of-run status popped on every DONE pulse.
module tb_adc_align_ctl;
  localparam int NL = 2;
  localparam int W  = 6;
  localparam int HO = 3;
  localparam int LC = 16;
  localparam int CW = 8;
  localparam logic [W-1:0] PAT = 6'b111000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL*W-1:0]   data;
  logic [NL*W-1:0]   pattern;
  logic [NL-1:0]     mask;
  logic              coherent;
  logic              start;
  logic [NL-1:0]     bs;
  logic [NL-1:0]     locked;
  logic [NL-1:0]     fail;
  logic              busy;
  logic              done;
  logic [NL*4-1:0]   slip_cnt;
  logic [NL*CW-1:0]  err_cnt;

  typedef struct {
    logic [NL-1:0]   locked;
    logic [NL-1:0]   fail;
    logic [NL*4-1:0] slip;
    int              bs0;
    int              bs1;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0;
  int           fails = 0;
  int           rot[NL];
  logic         force_en[NL];
  logic [W-1:0] force_word[NL];
  int           bsn[NL];
  int           cyc = 0;
  int           last1 = -1;
  int           min_gap1 = 1000;
  int           both_cnt = 0;
  int           single_cnt = 0;
  int           done_cnt = 0;

  always #5 clk = ~clk;

  adc_align_ctl #(.NLANES(NL), .W(W), .HOLDOFF(HO), .LOCKCNT(LC), .CNTW(CW)) dut (
    .CLK(clk), .RST_N(rst_n), .DATA(data), .PATTERN(pattern), .MASK(mask),
    .COHERENT(coherent), .START(start), .BS(bs), .LOCKED(locked), .FAIL(fail),
    .BUSY(busy), .DONE(done), .SLIP_CNT(slip_cnt), .ERR_CNT(err_cnt)
  );

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NL; i++) begin
      data[W*i +: W] = force_en[i] ? force_word[i] : rotl(PAT, rot[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, run the lane model
  // and the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (bs[i] === 1'b1) begin
        bsn[i]++;
        rot[i] = (rot[i] + W - 1) % W;
        if (i == 1) begin
          if (last1 >= 0 && (cyc - last1) < min_gap1) min_gap1 = cyc - last1;
          last1 = cyc;
        end
      end
    end
    if (bs === 2'b11) both_cnt++;
    if (bs === 2'b01 || bs === 2'b10) single_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      check("done_expected", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_locked", locked, e.locked);
        check("sb_fail", fail, e.fail);
        check("sb_slip_cnt", slip_cnt, e.slip);
        check("sb_bs0_pulses", bsn[0], e.bs0);
        check("sb_bs1_pulses", bsn[1], e.bs1);
      end
    end
  endtask

  task automatic launch(input int r0, input int r1, input logic coh);
    rot[0] = r0;
    rot[1] = r1;
    coherent = coh;
    bsn[0] = 0;
    bsn[1] = 0;
    last1 = -1;
    min_gap1 = 1000;
    both_cnt = 0;
    single_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int maxc);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < maxc) begin
      tick();
      k++;
    end
    check(tag, sbq.size(), 0);
  endtask

  initial begin
    int   k;
    int   d0;
    exp_t e;

    rst_n = 1'b0;
    start = 1'b0;
    coherent = 1'b0;
    mask = 2'b11;
    pattern = {PAT, PAT};
    for (int i = 0; i < NL; i++) begin
      rot[i] = 0; force_en[i] = 1'b0; force_word[i] = '0; bsn[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bs", bs, 0);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_slip", slip_cnt, 0);
    check("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_busy", busy, 0);
    check("idle_fail", fail, 0);

    // S1: aligned data, lock latency of 20 edges from START
    e = '{locked: 2'b11, fail: 2'b00, slip: 8'h00, bs0: 0, bs1: 0};
    sbq.push_back(e);
    d0 = done_cnt;
    launch(0, 0, 1'b0);
    check("s1_busy", busy, 1);
    k = 0;
    while (locked !== 2'b11 && k < 100) begin tick(); k++; end
    check("s1_lock_latency", k, 20);
    wait_run("s1_finished", 200);
    repeat (3) tick();
    check("s1_done_count", done_cnt - d0, 1);
    check("s1_err", err_cnt, 0);

    // S2: lane 1 rotated by 2
    e = '{locked: 2'b11, fail: 2'b00, slip: 8'h20, bs0: 0, bs1: 2};
    sbq.push_back(e);
    d0 = done_cnt;
    launch(0, 2, 1'b0);
    wait_run("s2_finished", 300);
    repeat (3) tick();
    check("s2_bs_gap_ge4", 32'(min_gap1 >= HO + 1), 1);
    check("s2_done_count", done_cnt - d0, 1);

    // S3: lane 0 held at a word that never matches
    force_en[0] = 1'b1;
    force_word[0] = 6'b101010;
    e = '{locked: 2'b10, fail: 2'b01, slip: 8'h05, bs0: 5, bs1: 0};
    sbq.push_back(e);
    d0 = done_cnt;
    launch(0, 0, 1'b0);
    wait_run("s3_finished", 300);
    repeat (3) tick();
    check("s3_done_count", done_cnt - d0, 1);
    check("s3_fail_held", fail, 2'b01);
    force_en[0] = 1'b0;

    // S4: lock both, then inject mismatches on lane 0 until saturation
    e = '{locked: 2'b11, fail: 2'b00, slip: 8'h00, bs0: 0, bs1: 0};
    sbq.push_back(e);
    launch(0, 0, 1'b0);
    wait_run("s4_finished", 200);
    repeat (3) tick();
    force_en[0] = 1'b1;
    force_word[0] = 6'b000111;
    repeat (100) tick();
    check("s4_err0_100", err_cnt[7:0], 100);
    repeat (200) tick();
    force_en[0] = 1'b0;
    check("s4_err0_sat", err_cnt[7:0], 255);
    check("s4_err1", err_cnt[15:8], 0);
    check("s4_locked", locked, 2'b11);
    check("s4_busy", busy, 0);

    // S5: coherent mode, both lanes rotated by 3; COHERENT dropped right after START
    e = '{locked: 2'b11, fail: 2'b00, slip: 8'h33, bs0: 3, bs1: 3};
    sbq.push_back(e);
    d0 = done_cnt;
    launch(3, 3, 1'b1);
    coherent = 1'b0;
    wait_run("s5_finished", 300);
    repeat (3) tick();
    check("s5_bs_both", both_cnt, 3);
    check("s5_bs_single", single_cnt, 0);
    check("s5_done_count", done_cnt - d0, 1);
    force_en[1] = 1'b1;
    force_word[1] = 6'b000111;
    repeat (10) tick();
    force_en[1] = 1'b0;
    check("s5_err1", err_cnt[15:8], 10);
    check("s5_err0", err_cnt[7:0], 0);

    // S6: START reasserted while alignment is in progress
    e = '{locked: 2'b11, fail: 2'b00, slip: 8'h00, bs0: 0, bs1: 0};
    sbq.push_back(e);
    d0 = done_cnt;
    launch(0, 1, 1'b0);
    repeat (8) tick();
    check("s6_slip_before", slip_cnt, 8'h10);
    check("s6_busy_before", busy, 1);
    bsn[0] = 0;
    bsn[1] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s6_slip_cleared", slip_cnt, 0);
    check("s6_busy_after", busy, 1);
    check("s6_locked_after", locked, 0);
    wait_run("s6_finished", 200);
    repeat (3) tick();
    check("s6_done_count", done_cnt - d0, 1);

    // S7: reset during a SLIP cycle
    d0 = done_cnt;
    launch(0, 1, 1'b0);
    k = 0;
    while (bs[1] !== 1'b1 && k < 30) begin tick(); k++; end
    check("s7_bs_seen", bs, 2'b10);
    rst_n = 1'b0;
    #1;
    check("s7_bs_rst", bs, 0);
    check("s7_locked_rst", locked, 0);
    check("s7_fail_rst", fail, 0);
    check("s7_busy_rst", busy, 0);
    check("s7_done_rst", done, 0);
    check("s7_slip_rst", slip_cnt, 0);
    check("s7_err_rst", err_cnt, 0);
    #3;
    rst_n = 1'b1;
    repeat (10) tick();
    check("s7_idle_busy", busy, 0);
    check("s7_idle_bs", bsn[1], 1);
    check("s7_no_done", done_cnt - d0, 0);

    // S8: START with every lane masked out
    mask = 2'b00;
    d0 = done_cnt;
    launch(0, 0, 1'b0);
    check("s8_busy_start", busy, 0);
    repeat (10) tick();
    check("s8_busy", busy, 0);
    check("s8_no_done", done_cnt - d0, 0);
    mask = 2'b11;

    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
